// File: rtl/act_c2_prober.sv
// act_c2_prober: sweeps all 16 select vectors into a C2 mux cell, recovers the
// four routed data words and flags vectors that disagree with their select code.
module act_c2_prober #(
   parameter int unsigned XLEN   = 8,
   parameter int unsigned SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] cell_out,
   output logic            A1,
   output logic            B1,
   output logic            A0,
   output logic            B0,
   output logic            busy,
   output logic            done,
   output logic            valid,
   output logic [XLEN-1:0] d00,
   output logic [XLEN-1:0] d01,
   output logic [XLEN-1:0] d10,
   output logic [XLEN-1:0] d11,
   output logic [15:0]     err_vec,
   output logic            err
);

   localparam int unsigned IW = 4;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
   localparam logic [IW-1:0] IDX_LAST    = IW'(15);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic [3:0]      seen;
   logic [1:0]      sel_c;
   logic [XLEN-1:0] word_c;

   // Expected select code for the current vector and the word stored for it
   always_comb begin
      sel_c  = {idx[3] | idx[2], idx[1] & idx[0]};
      word_c = d00;
      case (sel_c)
         2'd0:    word_c = d00;
         2'd1:    word_c = d01;
         2'd2:    word_c = d10;
         default: word_c = d11;
      endcase
   end

   // Sweep state machine with registered drive, capture and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         cnt     <= '0;
         seen    <= '0;
         A1      <= 1'b0;
         B1      <= 1'b0;
         A0      <= 1'b0;
         B0      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         valid   <= 1'b0;
         d00     <= '0;
         d01     <= '0;
         d10     <= '0;
         d11     <= '0;
         err_vec <= '0;
         err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state   <= DRIVE;
                  idx     <= '0;
                  cnt     <= '0;
                  seen    <= '0;
                  err_vec <= '0;
                  err     <= 1'b0;
                  valid   <= 1'b0;
                  busy    <= 1'b1;
                  {A1, B1, A0, B0} <= 4'h0;
               end
            end
            DRIVE: begin
               cnt <= cnt + CW'(1);
               if (cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (!seen[sel_c]) begin
                  seen[sel_c] <= 1'b1;
                  case (sel_c)
                     2'd0:    d00 <= cell_out;
                     2'd1:    d01 <= cell_out;
                     2'd2:    d10 <= cell_out;
                     default: d11 <= cell_out;
                  endcase
               end else if (cell_out != word_c) begin
                  err_vec[idx] <= 1'b1;
                  err          <= 1'b1;
               end
               if (idx == IDX_LAST) begin
                  state <= DONE;
                  done  <= 1'b1;
                  valid <= 1'b1;
                  busy  <= 1'b0;
                  {A1, B1, A0, B0} <= 4'h0;
               end else begin
                  state <= DRIVE;
                  idx   <= idx + IW'(1);
                  cnt   <= '0;
                  {A1, B1, A0, B0} <= idx + IW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_act_c2_prober.sv
// Directed bench for act_c2_prober: SETTLE=1 instance for function tests,
// SETTLE=3 instance for back-to-back sweeps.
module tb_act_c2_prober;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // SETTLE = 1 instance
   logic       start1 = 1'b0;
   logic [7:0] cell1;
   logic       a1_1, b1_1, a0_1, b0_1, busy1, done1, valid1, err1;
   logic [7:0] d00_1, d01_1, d10_1, d11_1;
   logic [15:0] ev1;
   logic [1:0] mode1 = 2'd0;

   // SETTLE = 3 instance
   logic       start3 = 1'b0;
   logic [7:0] cell3;
   logic       a1_3, b1_3, a0_3, b0_3, busy3, done3, valid3, err3;
   logic [7:0] d00_3, d01_3, d10_3, d11_3;
   logic [15:0] ev3;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   // Cell model: mode 0 ideal, 1 faulty S1 = A1&B1, 2 stuck at A5
   function automatic logic [7:0] cell_model(input logic [1:0] mode,
                                             input logic a1, input logic b1,
                                             input logic a0, input logic b0);
      logic [1:0] s;
      s[0] = a0 & b0;
      s[1] = (mode == 2'd1) ? (a1 & b1) : (a1 | b1);
      if (mode == 2'd2) return 8'hA5;
      case (s)
         2'd0:    return 8'h11;
         2'd1:    return 8'h22;
         2'd2:    return 8'h33;
         default: return 8'h44;
      endcase
   endfunction

   always_comb cell1 = cell_model(mode1, a1_1, b1_1, a0_1, b0_1);
   always_comb cell3 = cell_model(2'd0, a1_3, b1_3, a0_3, b0_3);

   act_c2_prober #(.XLEN(8), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .cell_out(cell1),
      .A1(a1_1), .B1(b1_1), .A0(a0_1), .B0(b0_1),
      .busy(busy1), .done(done1), .valid(valid1),
      .d00(d00_1), .d01(d01_1), .d10(d10_1), .d11(d11_1),
      .err_vec(ev1), .err(err1)
   );

   act_c2_prober #(.XLEN(8), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .cell_out(cell3),
      .A1(a1_3), .B1(b1_3), .A0(a0_3), .B0(b0_3),
      .busy(busy3), .done(done3), .valid(valid3),
      .d00(d00_3), .d01(d01_3), .d10(d10_3), .d11(d11_3),
      .err_vec(ev3), .err(err3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start1 for the accepting edge and return cycles until done1
   task automatic sweep1(output int lat);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_chk++;
      if ({a1_1, b1_1, a0_1, b0_1, busy1, done1, valid1, err1} !== 8'h00) begin
         $display("FAIL reset_ctrl: got %b want 00000000",
                  {a1_1, b1_1, a0_1, b0_1, busy1, done1, valid1, err1});
      end else n_pass++;
      n_chk++;
      if ({d00_1, d01_1, d10_1, d11_1, ev1} !== 48'h0) begin
         $display("FAIL reset_data: got %h want 0", {d00_1, d01_1, d10_1, d11_1, ev1});
      end else n_pass++;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ideal();
      int lat;
      mode1 = 2'd0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n_chk++;
      if (busy1 !== 1'b1) $display("FAIL ideal_busy: got %b want 1", busy1);
      else n_pass++;
      lat = 0;
      while (!done1 && lat < 200) begin
         tick();
         lat++;
      end
      n_chk++;
      if (lat !== 32) $display("FAIL ideal_latency: got %0d want 32", lat);
      else n_pass++;
      n_chk++;
      if ({d00_1, d01_1, d10_1, d11_1} !== 32'h11223344)
         $display("FAIL ideal_words: got %h want 11223344", {d00_1, d01_1, d10_1, d11_1});
      else n_pass++;
      n_chk++;
      if ({ev1, err1, valid1, busy1} !== {16'h0000, 1'b0, 1'b1, 1'b0})
         $display("FAIL ideal_status: got ev=%h err=%b valid=%b busy=%b want ev=0000 err=0 valid=1 busy=0",
                  ev1, err1, valid1, busy1);
      else n_pass++;
      tick();
      n_chk++;
      if ({done1, valid1} !== 2'b01) $display("FAIL ideal_done_pulse: got done=%b valid=%b want 0 1", done1, valid1);
      else n_pass++;
      tick();
   endtask

   task automatic test_faulty();
      int lat;
      mode1 = 2'd1;
      sweep1(lat);
      n_chk++;
      if (lat !== 32) $display("FAIL faulty_latency: got %0d want 32", lat);
      else n_pass++;
      n_chk++;
      if ({d00_1, d01_1, d10_1, d11_1} !== 32'h11221122)
         $display("FAIL faulty_words: got %h want 11221122", {d00_1, d01_1, d10_1, d11_1});
      else n_pass++;
      n_chk++;
      if ({ev1, err1} !== {16'hF000, 1'b1})
         $display("FAIL faulty_err: got ev=%h err=%b want F000 1", ev1, err1);
      else n_pass++;
      tick();
      tick();
   endtask

   task automatic test_stuck();
      int lat;
      mode1 = 2'd2;
      sweep1(lat);
      n_chk++;
      if ({d00_1, d01_1, d10_1, d11_1} !== 32'hA5A5A5A5)
         $display("FAIL stuck_words: got %h want a5a5a5a5", {d00_1, d01_1, d10_1, d11_1});
      else n_pass++;
      n_chk++;
      if ({ev1, err1, valid1} !== {16'h0000, 1'b0, 1'b1})
         $display("FAIL stuck_err: got ev=%h err=%b valid=%b want 0000 0 1", ev1, err1, valid1);
      else n_pass++;
      tick();
      tick();
   endtask

   task automatic test_drive();
      logic [3:0] exp_drv;
      int bad = 0;
      logic [3:0] bad_got = 4'h0;
      logic [3:0] bad_exp = 4'h0;
      mode1 = 2'd0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n_chk++;
      if (valid1 !== 1'b0) $display("FAIL drive_valid_clear: got %b want 0", valid1);
      else n_pass++;
      for (int k = 0; k < 32; k++) begin
         exp_drv = 4'(k >> 1);
         if ({a1_1, b1_1, a0_1, b0_1} !== exp_drv || done1 !== 1'b0) begin
            if (bad == 0) begin
               bad_got = {a1_1, b1_1, a0_1, b0_1};
               bad_exp = exp_drv;
            end
            bad++;
         end
         start1 = (k == 10) ? 1'b1 : 1'b0;
         tick();
      end
      start1 = 1'b0;
      n_chk++;
      if (bad !== 0)
         $display("FAIL drive_sequence: %0d bad cycles, first got %h want %h", bad, bad_got, bad_exp);
      else n_pass++;
      n_chk++;
      if ({done1, a1_1, b1_1, a0_1, b0_1} !== 5'b10000)
         $display("FAIL drive_done_timing: got done=%b drv=%b want 1 0000",
                  done1, {a1_1, b1_1, a0_1, b0_1});
      else n_pass++;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      int lat;
      int saw_done = 0;
      mode1 = 2'd0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int k = 0; k < 15; k++) tick();
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({a1_1, b1_1, a0_1, b0_1, busy1, done1, valid1, err1, d00_1, d01_1, d10_1, d11_1, ev1} !== 56'h0)
         $display("FAIL midreset_outputs: got %h want 0",
                  {a1_1, b1_1, a0_1, b0_1, busy1, done1, valid1, err1, d00_1, d01_1, d10_1, d11_1, ev1});
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done1) saw_done++;
      end
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done1) saw_done++;
      end
      n_chk++;
      if (saw_done !== 0) $display("FAIL midreset_no_done: got %0d done cycles want 0", saw_done);
      else n_pass++;
      sweep1(lat);
      n_chk++;
      if ({lat[7:0], d00_1, d01_1, d10_1, d11_1, ev1} !== {8'd32, 32'h11223344, 16'h0000})
         $display("FAIL midreset_resweep: got lat=%0d words=%h ev=%h want 32 11223344 0000",
                  lat, {d00_1, d01_1, d10_1, d11_1}, ev1);
      else n_pass++;
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      start3 = 1'b1;
      tick();
      lat = 0;
      while (!done3 && lat < 300) begin
         tick();
         lat++;
      end
      n_chk++;
      if (lat !== 64) $display("FAIL b2b_latency1: got %0d want 64", lat);
      else n_pass++;
      n_chk++;
      if ({d00_3, d01_3, d10_3, d11_3, ev3, valid3} !== {32'h11223344, 16'h0000, 1'b1})
         $display("FAIL b2b_result1: got words=%h ev=%h valid=%b want 11223344 0000 1",
                  {d00_3, d01_3, d10_3, d11_3}, ev3, valid3);
      else n_pass++;
      tick();
      n_chk++;
      if ({done3, busy3, valid3} !== 3'b001)
         $display("FAIL b2b_gap: got done=%b busy=%b valid=%b want 0 0 1", done3, busy3, valid3);
      else n_pass++;
      tick();
      n_chk++;
      if ({busy3, valid3} !== 2'b10)
         $display("FAIL b2b_accept2: got busy=%b valid=%b want 1 0", busy3, valid3);
      else n_pass++;
      lat = 0;
      while (!done3 && lat < 300) begin
         tick();
         lat++;
      end
      start3 = 1'b0;
      n_chk++;
      if (lat !== 64) $display("FAIL b2b_latency2: got %0d want 64", lat);
      else n_pass++;
      n_chk++;
      if ({d00_3, d01_3, d10_3, d11_3, ev3, valid3} !== {32'h11223344, 16'h0000, 1'b1})
         $display("FAIL b2b_result2: got words=%h ev=%h valid=%b want 11223344 0000 1",
                  {d00_3, d01_3, d10_3, d11_3}, ev3, valid3);
      else n_pass++;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_faulty();
      test_stuck();
      test_drive();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
